uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter (transmit/data/busy handshake, 9600 baud) between N_REQ producers,
//  e.g. the post-op sensor channels. Round-robin arbitration; each grant is sent as a 2-byte

---
 rtl/uart_tx_arbiter_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter_rr.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
//   state_e : arbiter FSM states
//   phase_e : which byte of the 2-byte packet is being sent
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StStart,
    StWaitHi,
    StWaitLo
  } state_e;

  typedef enum logic {
    PhHdr,
    PhDat
  } phase_e;

  localparam logic [3:0]  HdrTagDefault  = 4'hA;
  localparam int unsigned TimeoutDefault = 20000;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of producer-side and UART-side handshake signals around the arbiter.
//   req/req_data/ack          : level requests, flattened data, one-hot consume pulse
//   tx_transmit/tx_data/tx_busy : UART byte handshake
//   active/err_timeout        : status
// Modports: slave = the arbiter, master = the surrounding system (producers + UART).
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_BW = 8
);

  logic [N_REQ-1:0]         req;
  logic [N_REQ*DATA_BW-1:0] req_data;
  logic [N_REQ-1:0]         ack;
  logic                     tx_transmit;
  logic [DATA_BW-1:0]       tx_data;
  logic                     tx_busy;
  logic                     active;
  logic                     err_timeout;

  modport slave (
    input  req, req_data, tx_busy,
    output ack, tx_transmit, tx_data, active, err_timeout
  );

  modport master (
    output req, req_data, tx_busy,
    input  ack, tx_transmit, tx_data, active, err_timeout
  );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin selector.
//   req_i         : pending requests
//   ptr_i         : index of the last granted requester
//   grant_id_o    : first pending requester after ptr_i, wrapping N_REQ-1 -> 0
//   grant_valid_o : any request pending
module uart_tx_arbiter_rr #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_BW = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_BW-1:0] ptr_i,
  output logic [ID_BW-1:0] grant_id_o,
  output logic             grant_valid_o
);

  logic [ID_BW-1:0] idx;

  // Walk N_REQ slots starting just after the pointer; the pointer itself is
  // visited last, so a held request yields to every other pending one.
  always_comb begin
    grant_id_o    = '0;
    grant_valid_o = 1'b0;
    idx           = ptr_i;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (idx == ID_BW'(N_REQ - 1)) begin
        idx = '0;
      end else begin
        idx = idx + ID_BW'(1);
      end
      if (!grant_valid_o && req_i[idx]) begin
        grant_id_o    = idx;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ producers. Each grant becomes a
// 2-byte packet: header {HDR_TAG, zero-extended id}, then the producer's byte.
//   clk, rst : system clock, asynchronous active-high reset
//   arb_io   : slave side of uart_tx_arbiter_if (producers + UART handshake)
// A transmitted byte that never raises tx_busy within TIMEOUT clocks aborts the
// packet with an err_timeout pulse; the packet is dropped, not retried.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_BW = 8,
  parameter int unsigned ID_BW   = 2,
  parameter logic [3:0]  HDR_TAG = HdrTagDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault,
  parameter int unsigned TO_BW   = 15
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave arb_io
);

  localparam int unsigned LowBw = DATA_BW - 4;

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [ID_BW-1:0]   ptr_q, ptr_d;
  logic [DATA_BW-1:0] data_q, data_d;
  logic [DATA_BW-1:0] tx_data_q, tx_data_d;
  logic [TO_BW-1:0]   to_cnt_q, to_cnt_d;

  logic [ID_BW-1:0]   grant_id;
  logic               grant_valid;
  logic [DATA_BW-1:0] sel_data;
  logic               to_expired;

  uart_tx_arbiter_rr #(
    .N_REQ (N_REQ),
    .ID_BW (ID_BW)
  ) u_rr (
    .req_i         (arb_io.req),
    .ptr_i         (ptr_q),
    .grant_id_o    (grant_id),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_BW'(i)) begin
        sel_data = arb_io.req_data[i*DATA_BW +: DATA_BW];
      end
    end
  end

  assign to_expired = (to_cnt_q == TO_BW'(TIMEOUT - 1));

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      phase_q   <= PhHdr;
      ptr_q     <= ID_BW'(N_REQ - 1);
      data_q    <= '0;
      tx_data_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ptr_q     <= ptr_d;
      data_q    <= data_d;
      tx_data_q <= tx_data_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    tx_data_d = tx_data_q;
    to_cnt_d  = to_cnt_q;
    unique case (state_q)
      StIdle: begin
        // A busy UART here is a foreign or leftover frame: hold off.
        if ((|arb_io.req) && !arb_io.tx_busy) begin
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (grant_valid) begin
          state_d   = StStart;
          ptr_d     = grant_id;
          data_d    = sel_data;
          phase_d   = PhHdr;
          // Header is loaded now so it is already on tx_data during the pulse.
          tx_data_d = {HDR_TAG, LowBw'(grant_id)};
        end else begin
          state_d = StIdle;
        end
      end
      StStart: begin
        to_cnt_d = '0;
        state_d  = StWaitHi;
      end
      StWaitHi: begin
        if (arb_io.tx_busy) begin
          state_d = StWaitLo;
        end else if (to_expired) begin
          state_d = StIdle;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + TO_BW'(1);
        end
      end
      StWaitLo: begin
        if (!arb_io.tx_busy) begin
          if (phase_q == PhHdr) begin
            phase_d   = PhDat;
            tx_data_d = data_q;
            state_d   = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    arb_io.ack         = '0;
    arb_io.tx_transmit = 1'b0;
    arb_io.err_timeout = 1'b0;
    unique case (state_q)
      StGrant:  if (grant_valid) arb_io.ack = N_REQ'(1) << grant_id;
      StStart:  arb_io.tx_transmit = 1'b1;
      StWaitHi: arb_io.err_timeout = !arb_io.tx_busy && to_expired;
      default:  ;
    endcase
  end

  assign arb_io.tx_data = tx_data_q;
  assign arb_io.active  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic clk;
  logic rst;
  int   cyc = 0;

  uart_tx_arbiter_if #(.N_REQ(4), .DATA_BW(8)) arb ();

  uart_tx_arbiter #(
    .N_REQ   (4),
    .DATA_BW (8),
    .ID_BW   (2),
    .HDR_TAG (4'hA),
    .TIMEOUT (20000),
    .TO_BW   (15)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_io (arb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural UART: busy rises rise_dly clocks after transmit, stays high hi_len clocks.
  logic model_busy = 1'b0;
  logic ext_busy   = 1'b0;
  logic mute       = 1'b0;
  int   rise_dly   = 3;
  int   hi_len     = 20;
  int   m_dly      = 0;
  int   m_hi       = 0;

  assign arb.tx_busy = model_busy | ext_busy;

  always @(negedge clk) begin
    if (m_dly != 0) begin
      m_dly <= m_dly - 1;
      if (m_dly == 1) begin
        model_busy <= 1'b1;
        m_hi       <= hi_len;
      end
    end else if (m_hi != 0) begin
      m_hi <= m_hi - 1;
      if (m_hi == 1) model_busy <= 1'b0;
    end
    if (arb.tx_transmit && !mute) m_dly <= rise_dly;
  end

  // Observation logs.
  logic [3:0] ack_log[$];
  logic [7:0] tx_log[$];
  logic [3:0] exp_ack[$];
  logic [7:0] exp_tx[$];
  int         t_tx = 0;

  always @(negedge clk) begin
    if (arb.ack != 4'b0) ack_log.push_back(arb.ack);
    if (arb.tx_transmit) begin
      tx_log.push_back(arb.tx_data);
      t_tx = cyc;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    ack_log.delete();
    tx_log.delete();
    exp_ack.delete();
    exp_tx.delete();
  endtask

  task automatic compare_logs(input string tag);
    check_eq({tag, "_nack"}, ack_log.size(), exp_ack.size());
    for (int i = 0; i < exp_ack.size(); i++) begin
      if (i < ack_log.size()) check_eq($sformatf("%s_ack%0d", tag, i), ack_log[i], exp_ack[i]);
    end
    check_eq({tag, "_ntx"}, tx_log.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (i < tx_log.size()) check_eq($sformatf("%s_tx%0d", tag, i), tx_log[i], exp_tx[i]);
    end
  endtask

  task automatic wait_ack(input string tag, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (arb.ack != 4'b0) ok = 1'b1;
    end
    check_eq({tag, "_ack_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (!arb.active && !arb.tx_busy && m_dly == 0) ok = 1'b1;
    end
    check_eq({tag, "_done"}, 32'(ok), 32'd1);
  endtask

  // Raise a request, wait for its ack, drop it on the next clock.
  task automatic send_one(input string tag, input logic [3:0] m);
    @(posedge clk);
    #1 arb.req = arb.req | m;
    wait_ack(tag, 200);
    @(posedge clk);
    #1 arb.req = arb.req & ~m;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  t_err;
    int  lat;
    bit  ok;

    rst          = 1'b1;
    arb.req      = '0;
    arb.req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack",    arb.ack, 0);
    check_eq("rst_tx",     arb.tx_transmit, 0);
    check_eq("rst_txdata", arb.tx_data, 0);
    check_eq("rst_active", arb.active, 0);
    check_eq("rst_err",    arb.err_timeout, 0);
    rst = 1'b0;

    // 1: single producer 2.
    clear_logs();
    arb.req_data[23:16] = 8'h5C;
    send_one("t1", 4'b0100);
    wait_done("t1", 300);
    exp_ack = '{4'b0100};
    exp_tx  = '{8'hA2, 8'h5C};
    compare_logs("t1");

    // 2: all four held; strict rotation starting after the last grant (id 2).
    clear_logs();
    arb.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    @(posedge clk);
    #1 arb.req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_ack($sformatf("t2_%0d", i), 200);
    @(posedge clk);
    #1 arb.req = 4'b0000;
    wait_done("t2", 300);
    exp_ack = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_tx  = '{8'hA3, 8'h13, 8'hA0, 8'h10, 8'hA1, 8'h11, 8'hA2, 8'h12, 8'hA3, 8'h13};
    compare_logs("t2");

    // 3: req0 held, req3 arrives mid-packet and is served next.
    clear_logs();
    arb.req_data = {8'h33, 8'h00, 8'h00, 8'h30};
    @(posedge clk);
    #1 arb.req = 4'b0001;
    wait_ack("t3_a", 200);
    repeat (10) @(posedge clk);
    #1 arb.req = 4'b1001;
    wait_ack("t3_b", 200);
    @(posedge clk);
    #1 arb.req = 4'b0000;
    wait_done("t3", 300);
    exp_ack = '{4'b0001, 4'b1000};
    exp_tx  = '{8'hA0, 8'h30, 8'hA3, 8'h33};
    compare_logs("t3");

    // 4: UART never answers -> timeout exactly 20000 clocks after the pulse.
    clear_logs();
    mute = 1'b1;
    arb.req_data[15:8] = 8'h77;
    send_one("t4", 4'b0010);
    ok = 1'b0;
    t_err = 0;
    for (int i = 0; i < 20100 && !ok; i++) begin
      @(negedge clk);
      if (arb.err_timeout) begin
        ok    = 1'b1;
        t_err = cyc;
      end
    end
    check_eq("t4_err_seen", 32'(ok), 32'd1);
    check_eq("t4_err_time", t_err - t_tx, 20000);
    @(negedge clk);
    check_eq("t4_active", arb.active, 0);
    check_eq("t4_err_pulse", arb.err_timeout, 0);
    exp_ack = '{4'b0010};
    exp_tx  = '{8'hA1};
    compare_logs("t4");
    mute = 1'b0;
    clear_logs();
    arb.req_data[23:16] = 8'h21;
    send_one("t4b", 4'b0100);
    wait_done("t4b", 300);
    exp_ack = '{4'b0100};
    exp_tx  = '{8'hA2, 8'h21};
    compare_logs("t4b");

    // 5: reset while waiting for busy to fall on the data byte.
    clear_logs();
    arb.req_data[7:0] = 8'h5A;
    @(posedge clk);
    #1 arb.req = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (tx_log.size() == 2 && arb.tx_busy) ok = 1'b1;
    end
    check_eq("t5_in_waitlo", 32'(ok), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("t5_rst_active", arb.active, 0);
    check_eq("t5_rst_tx",     arb.tx_transmit, 0);
    check_eq("t5_rst_txdata", arb.tx_data, 0);
    check_eq("t5_rst_ack",    arb.ack, 0);
    clear_logs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("t5_busy_still", arb.tx_busy, 1);
    check_eq("t5_no_ack", ack_log.size(), 0);
    wait_ack("t5_regrant", 40);
    @(posedge clk);
    #1 arb.req = 4'b0000;
    wait_done("t5", 300);
    exp_ack = '{4'b0001};
    exp_tx  = '{8'hA0, 8'h5A};
    compare_logs("t5");

    // 6: busy already high when reset is released.
    clear_logs();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    ext_busy = 1'b1;
    arb.req  = 4'b0100;
    arb.req_data[23:16] = 8'h66;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("t6_no_ack", ack_log.size(), 0);
    check_eq("t6_idle", arb.active, 0);
    @(posedge clk);
    #1 ext_busy = 1'b0;
    lat = 0;
    ok  = 1'b0;
    for (int i = 1; i <= 5 && !ok; i++) begin
      @(negedge clk);
      if (arb.ack != 4'b0) begin
        ok  = 1'b1;
        lat = i;
      end
    end
    check_eq("t6_ack_lat", lat, 2);
    @(posedge clk);
    #1 arb.req = 4'b0000;
    wait_done("t6", 300);
    exp_ack = '{4'b0100};
    exp_tx  = '{8'hA2, 8'h66};
    compare_logs("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
